deltaw_engine: RTL and testbench
================================

# deltaw_engine

Parametrised delta-weight generator for the DQN backprop path. For one output neuron it takes a latched error term `delta` and streams in `N_IN` input-layer activations. It accumulates each product `in_data*delta` per input index over a mini-batch of `batch_len` samples. After the last sample it streams out learning-rate-scaled, saturated Q(DATA_W-FRAC_W).FRAC_W weight updates through a valid/ready port to the weight-update stage.

## Interface
- `DATA_W`, 16, width of activations, delta and weight updates (signed, FRAC_W fractional bits)
- `FRAC_W`, 10, fractional bits of the fixed-point format
- `N_IN`, 8, input-layer elements per sample (≥2)
- `MAX_BATCH`, 16, largest supported mini-batch
- Derived: IDX_W = clog2(N_IN); BCNT_W = clog2(MAX_BATCH+1); ACC_W = 2*DATA_W + clog2(MAX_BATCH)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin one sample; samples `delta`, `lr_shift`, `batch_len` (the last two only on the batch's first sample)
- `delta` in DATA_W: signed error term for this sample
- `lr_shift` in 4: learning rate = 2^-lr_shift
- `batch_len` in BCNT_W: samples per batch; 0 is treated as 1, values >MAX_BATCH are clamped to MAX_BATCH
- `busy` out 1: high whenever state ≠ IDLE
- `in_valid` in 1 / `in_ready` out 1 / `in_data` in DATA_W: activation stream, element index implicit 0..N_IN-1
- `out_valid` out 1 / `out_ready` in 1 / `out_data` out DATA_W: weight-update stream
- `out_idx` out IDX_W: input index of `out_data`
- `out_sat` out 1: `out_data` was clipped
- `done` out 1: one-cycle pulse after the last update is accepted

## Operation
- State machine: IDLE, LOAD, EMIT.
- IDLE: `in_ready`=0, `out_valid`=0. On `start`:
  - latch `delta`.
  - If the sample counter `scnt`=0, also latch `lr_shift` and the effective `batch_len`.
  - Go to LOAD with element counter `k`=0.
  - `start` is ignored in any other state.
- LOAD: `in_ready`=1. On each `in_valid&&in_ready`:
  - acc[k] <= (scnt==0 ? 0 : acc[k]) + sext(in_data*delta).
  - The product is full 2*DATA_W signed; the accumulator is ACC_W signed and never overflows.
  - k increments.
  - On the element with k=N_IN-1: scnt increments. If the new scnt equals the batch length, go to EMIT with k=0; otherwise go to IDLE and wait for the next sample's `start`.
- EMIT:
  - out_data = sat(acc[k] >>> (FRAC_W + lr_shift)). The shift is arithmetic (floor toward −∞).
  - sat clips to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; `out_sat`=1 when clipping occurred.
  - `out_idx`=k.
  - Hold all outputs stable while `out_valid && !out_ready`.
  - Advance k on each handshake. After the handshake at k=N_IN-1: pulse `done`, clear scnt, go to IDLE.
- Accumulators are not cleared on exit. They are overwritten by the first sample of the next batch.
- Reset, including mid-LOAD or mid-EMIT: state IDLE, k=0, scnt=0, all accumulators 0, and the partial batch is discarded.
  - Output reset values: `busy`=0, `in_ready`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `out_sat`=0, `done`=0.

## Timing
- `start` at cycle t: `busy` and `in_ready` go high at t+1.
- LOAD accepts one element per cycle. N_IN elements with `in_valid` held high take N_IN cycles.
- Last element accepted at cycle t: at t+1, either `out_valid`=1 with idx 0 (batch complete), or IDLE with `in_ready`=0.
- EMIT sends one update per cycle under continuous `out_ready`. Batch latency from the last input to the last output is N_IN cycles.
- `done` is asserted the cycle after the final output handshake, coincident with `busy`=0. A `start` in that cycle is accepted.
- A `start` asserted in the same cycle as the final LOAD or EMIT handshake is ignored.
- `out_data`, `out_idx` and `out_sat` are registered. They are valid only while `out_valid`=1.

## Test plan
- Basic scale, N_IN=8, batch_len=1, lr_shift=5: delta=4096 (4.0) and all in_data=4096 -> all 8 out_data=512 (0.5), out_sat=0; then `done` pulses once.
- Sign handling: elements alternating ±4096 with delta=−4096 -> out_data alternates −512 / +512. Element in=1, delta=1, lr_shift=0 -> 0; element in=−1, delta=1, lr_shift=0 -> −1 (floor).
- Saturation: in=32767, delta=32767, lr_shift=0 -> out_data=32767, out_sat=1. In the same run, in=−32768, delta=32767 -> out_data=−32768, out_sat=1.
- Batch accumulate: batch_len=2, lr_shift=5, two samples each with delta=4096 and in=4096 -> no out_valid after sample 1, then out_data=1024 for all indices. A second batch with batch_len=1 -> 512, showing the accumulators were overwritten.
- Handshakes: random `in_valid` gaps and `out_ready` low for 3 cycles at idx 2 -> no element is lost, and out_data/out_idx stay stable while stalled. `start` pulsed during LOAD and EMIT -> ignored. batch_len=0 behaves as 1.
- Reset mid-EMIT at idx 3 -> next cycle all outputs are at reset values. A fresh batch_len=1 run then yields the correct results with no residue from the aborted batch.

Source files
------------

// File: rtl/deltaw_engine.sv
// deltaw_engine
//   Delta-weight generator for one output neuron. Each sample latches an
//   error term `delta` and streams N_IN activations; every product
//   in_data*delta is accumulated per input index across a mini-batch.
//   Once the batch is complete the accumulators are scaled by
//   2^-(FRAC_W+lr_shift), saturated to DATA_W bits and streamed out.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   start               begin a sample (IDLE only); latches delta, and on
//                       the first sample of a batch also lr_shift/batch_len
//   delta               signed error term
//   lr_shift            learning rate exponent (rate = 2^-lr_shift)
//   batch_len           samples per batch (0 -> 1, >MAX_BATCH -> MAX_BATCH)
//   busy                high whenever the engine is not IDLE
//   in_valid/in_ready/in_data     activation stream, index 0..N_IN-1
//   out_valid/out_ready/out_data  weight-update stream
//   out_idx             input index of out_data
//   out_sat             out_data was clipped
//   done                one-cycle pulse after the last update is accepted
//   state_dbg           current FSM state (0 IDLE, 1 LOAD, 2 EMIT)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds data stable while valid && !ready and does
// not withdraw valid before the transfer.
module deltaw_engine #(
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 10,
    parameter int N_IN      = 8,
    parameter int MAX_BATCH = 16,
    localparam int IDX_W    = $clog2(N_IN),
    localparam int BCNT_W   = $clog2(MAX_BATCH + 1),
    localparam int ACC_W    = 2 * DATA_W + $clog2(MAX_BATCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] delta,
    input  logic [3:0]        lr_shift,
    input  logic [BCNT_W-1:0] batch_len,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_sat,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] OUT_HI = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] OUT_LO = {1'b1, {(DATA_W-1){1'b0}}};

    state_t                   state;
    logic [IDX_W-1:0]         k;
    logic [BCNT_W-1:0]        scnt;
    logic [BCNT_W-1:0]        blen;
    logic [3:0]               lr_r;
    logic [DATA_W-1:0]        delta_r;
    logic signed [ACC_W-1:0]  acc [N_IN];

    logic [BCNT_W-1:0]        blen_eff;
    logic [BCNT_W-1:0]        scnt_inc;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_add;
    logic [IDX_W-1:0]         sel;
    logic [5:0]               shamt;
    logic signed [ACC_W-1:0]  shifted;
    logic [DATA_W-1:0]        scaled;
    logic                     scaled_sat;

    assign busy      = (state != S_IDLE);
    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_EMIT);
    assign state_dbg = state;

    always_comb begin
        blen_eff = batch_len;
        if (batch_len == '0)
            blen_eff = BCNT_W'(1);
        else if (batch_len > BCNT_W'(MAX_BATCH))
            blen_eff = BCNT_W'(MAX_BATCH);

        scnt_inc = scnt + 1'b1;
        prod     = $signed(in_data) * $signed(delta_r);
        // First sample of a batch overwrites whatever the last batch left.
        acc_add  = ((scnt == '0) ? '0 : acc[k]) + ACC_W'(prod);

        // The registered output is loaded one entry ahead: index 0 while
        // finishing LOAD (acc[0] is already final then), k+1 during EMIT.
        sel = '0;
        if (state == S_EMIT && k != LAST)
            sel = k + 1'b1;

        shamt   = 6'(FRAC_W) + 6'(lr_r);
        shifted = acc[sel] >>> shamt;

        scaled     = shifted[DATA_W-1:0];
        scaled_sat = 1'b0;
        if (shifted > SAT_HI) begin
            scaled     = OUT_HI;
            scaled_sat = 1'b1;
        end else if (shifted < SAT_LO) begin
            scaled     = OUT_LO;
            scaled_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            k        <= '0;
            scnt     <= '0;
            blen     <= '0;
            lr_r     <= '0;
            delta_r  <= '0;
            out_data <= '0;
            out_idx  <= '0;
            out_sat  <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < N_IN; i++)
                acc[i] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        delta_r <= delta;
                        if (scnt == '0) begin
                            lr_r <= lr_shift;
                            blen <= blen_eff;
                        end
                        k     <= '0;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        acc[k] <= acc_add;
                        if (k == LAST) begin
                            k    <= '0;
                            scnt <= scnt_inc;
                            if (scnt_inc == blen) begin
                                state    <= S_EMIT;
                                out_data <= scaled;
                                out_sat  <= scaled_sat;
                                out_idx  <= '0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (k == LAST) begin
                            k     <= '0;
                            scnt  <= '0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            k        <= k + 1'b1;
                            out_data <= scaled;
                            out_sat  <= scaled_sat;
                            out_idx  <= k + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_deltaw_engine.sv
// Testbench for deltaw_engine: directed sample vectors with hand-computed
// weight updates, checked by a queue-based scoreboard monitor.
module tb_deltaw_engine;

    localparam int DATA_W = 16;
    localparam int IDX_W  = 3;
    localparam int BCNT_W = 5;

    typedef logic signed [DATA_W-1:0] vec_t [8];

    logic              clk;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] delta;
    logic [3:0]        lr_shift;
    logic [BCNT_W-1:0] batch_len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_sat;
    logic              done;
    logic [1:0]        state_dbg;

    deltaw_engine #(
        .DATA_W(16), .FRAC_W(10), .N_IN(8), .MAX_BATCH(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .delta(delta),
        .lr_shift(lr_shift), .batch_len(batch_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_sat(out_sat), .done(done),
        .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard: entries are {sat, idx, data}
    logic [DATA_W+IDX_W:0] exp_q[$];
    int n_vec    = 0;
    int n_miss   = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_batch(input vec_t e, input logic [7:0] sat);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({sat[i], IDX_W'(i), e[i]});
    endtask

    // monitor
    initial begin : monitor
        logic                  stall_q;
        logic [DATA_W+IDX_W:0] held;
        logic [DATA_W+IDX_W:0] cur;
        logic [DATA_W+IDX_W:0] e;
        stall_q = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_q = 1'b0;
            end else begin
                if (done) begin
                    done_cnt++;
                    chk("done_with_busy_low", busy, 0);
                end
                if (out_valid) begin
                    cur = {out_sat, out_idx, out_data};
                    if (stall_q) chk("stall_hold", cur, held);
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_output", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_idx", out_idx, e[DATA_W+IDX_W-1:DATA_W]);
                            chk("out_data", $signed(out_data), $signed(e[DATA_W-1:0]));
                            chk("out_sat", out_sat, e[DATA_W+IDX_W]);
                        end
                        stall_q = 1'b0;
                    end else begin
                        stall_q = 1'b1;
                        held    = cur;
                    end
                end
            end
        end
    end

    // drivers
    task automatic send_sample(input logic signed [15:0] d, input logic [3:0] lr,
                               input logic [BCNT_W-1:0] bl, input vec_t x,
                               input int gap_max, input bit poke, input bit exp_emit);
        start = 1'b1; delta = d; lr_shift = lr; batch_len = bl;
        @(posedge clk); #1;
        start = 1'b0; delta = 16'h5a5a; lr_shift = 4'd15; batch_len = 5'd7;
        chk("busy_after_start", busy, 1);
        chk("in_ready_after_start", in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = x[i];
            if (poke && i == 3) begin
                start = 1'b1;
                delta = 16'h7fff;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            start    = 1'b0;
        end
        chk("out_valid_after_load", out_valid, exp_emit);
        chk("in_ready_after_load", in_ready, 0);
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while ((exp_q.size() != 0 || done_cnt == prev) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("done_count", done_cnt, prev + 1);
        chk("busy_after_done", busy, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("done_single_pulse", done_cnt, prev + 1);
    endtask

    task automatic wait_idx(input logic [IDX_W-1:0] idx);
        int n = 0;
        while (!(out_valid && out_idx == idx) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_emit_idx", out_valid && out_idx == idx, 1);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, 0);
    endtask

    // stimulus
    initial begin : main
        vec_t x, e;
        int   prev;
        rst = 1'b1; start = 1'b0; delta = '0; lr_shift = '0; batch_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        // basic scale: 4.0*4.0 >> 5 = 0.5
        x = '{default: 16'sd4096};
        e = '{default: 16'sd512};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(16'sd4096, 4'd5, 5'd1, x, 0, 1'b0, 1'b1);
        wait_done(prev);

        // sign handling with negative delta
        x = '{16'sd4096, -16'sd4096, 16'sd4096, -16'sd4096,
              16'sd4096, -16'sd4096, 16'sd4096, -16'sd4096};
        e = '{-16'sd512, 16'sd512, -16'sd512, 16'sd512,
              -16'sd512, 16'sd512, -16'sd512, 16'sd512};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(-16'sd4096, 4'd5, 5'd1, x, 0, 1'b0, 1'b1);
        wait_done(prev);

        // floor behaviour of the arithmetic shift, delta=1, lr_shift=0
        x = '{16'sd1, -16'sd1, 16'sd1024, -16'sd1024,
              16'sd32767, -16'sd32768, 16'sd0, 16'sd5};
        e = '{16'sd0, -16'sd1, 16'sd1, -16'sd1,
              16'sd31, -16'sd32, 16'sd0, 16'sd0};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(16'sd1, 4'd0, 5'd1, x, 0, 1'b0, 1'b1);
        wait_done(prev);

        // saturation, plus exact full-scale values that must not clip
        x = '{16'sd32767, -16'sd32768, 16'sd0, 16'sd1024,
              -16'sd1024, 16'sd32767, -16'sd1, 16'sd2};
        e = '{16'sd32767, -16'sd32768, 16'sd0, 16'sd32767,
              -16'sd32767, 16'sd32767, -16'sd32, 16'sd63};
        prev = done_cnt;
        push_batch(e, 8'b0010_0011);
        send_sample(16'sd32767, 4'd0, 5'd1, x, 0, 1'b0, 1'b1);
        wait_done(prev);

        // batch of two; lr_shift/batch_len on the second sample are ignored
        x = '{default: 16'sd4096};
        send_sample(16'sd4096, 4'd5, 5'd2, x, 0, 1'b0, 1'b0);
        chk("busy_between_samples", busy, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("no_output_mid_batch", out_valid, 0);
        e = '{default: 16'sd1024};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(16'sd4096, 4'd9, 5'd0, x, 0, 1'b0, 1'b1);
        wait_done(prev);

        // next batch of one overwrites the accumulators
        e = '{default: 16'sd512};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(16'sd4096, 4'd5, 5'd1, x, 0, 1'b0, 1'b1);
        wait_done(prev);

        // input gaps, start poked during LOAD and EMIT, 3-cycle stall at idx 2
        x = '{16'sd4096, 16'sd8192, -16'sd4096, 16'sd2048,
              16'sd0, 16'sd4096, 16'sd4096, -16'sd8192};
        e = '{16'sd512, 16'sd1024, -16'sd512, 16'sd256,
              16'sd0, 16'sd512, 16'sd512, -16'sd1024};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(16'sd4096, 4'd5, 5'd1, x, 3, 1'b1, 1'b1);
        wait_idx(3'd2);
        out_ready = 1'b0;
        start     = 1'b1;
        delta     = 16'h7fff;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_while_stalled", busy, 1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("valid_while_stalled", out_valid, 1);
        chk("idx_while_stalled", out_idx, 2);
        out_ready = 1'b1;
        wait_done(prev);

        // batch_len=0 behaves as 1
        x = '{default: 16'sd4096};
        e = '{default: 16'sd512};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(16'sd4096, 4'd5, 5'd0, x, 0, 1'b0, 1'b1);
        wait_done(prev);

        // reset mid-EMIT at idx 3
        x = '{default: 16'sd8192};
        e = '{default: 16'sd2048};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(16'sd8192, 4'd5, 5'd1, x, 0, 1'b0, 1'b1);
        wait_idx(3'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs();
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        chk("no_done_after_reset", done_cnt, prev);

        // fresh run after the abort
        x = '{default: 16'sd4096};
        e = '{default: -16'sd512};
        prev = done_cnt;
        push_batch(e, 8'h00);
        send_sample(-16'sd4096, 4'd5, 5'd1, x, 0, 1'b0, 1'b1);
        wait_done(prev);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
